flags_stack_seq: RTL
====================

Name: flags_stack_seq

Overview:
- Sequencer that moves the architectural flags between the Flags register and the stack.
- Used for PUSHF, for the flags push at interrupt entry, and for POPF and IRET.
- Save path: captures flags_out, writes the image to SS:SP-2 over the stack memory handshake, updates SP, and optionally clears IF/TF.
- Restore path: reads SS:SP and drives flags_in/update_flags back into the Flags register.
- Sits between microcode control, the register file SP port and the load/store unit.

Parameters:
- STACK_STEP, default 2: byte decrement applied on save and increment applied on restore.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start_save  in  1  one-cycle request to push flags
- start_restore  in  1  one-cycle request to pop flags
- clear_it  in  1  sampled with start_save; clear IF and TF after the push
- sp_in  in  16  current SP, sampled on an accepted start
- flags_out  in  16  current flags from the Flags register, sampled on accepted start_save
- flags_in  out  16  flags image driven to the Flags register
- update_flags  out  9  per-flag write enables to the Flags register, using UpdateFlags_* bit positions
- sp_out  out  16  new SP value
- sp_wr_en  out  1  one-cycle SP write strobe
- m_addr  out  16  stack offset (SS applied downstream)
- m_data_out  out  16  write data
- m_data_in  in  16  read data, valid when m_ack is high
- m_access  out  1  memory request
- m_wr_en  out  1  write qualifier for m_access
- m_ack  in  1  one-cycle completion
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: async; state goes to IDLE immediately, including mid-transaction.
  - All outputs reset to 0: flags_in, update_flags, sp_out, sp_wr_en, m_addr, m_data_out, m_access, m_wr_en, busy, done.
  - An m_ack arriving after reset is ignored.
- States: IDLE, SAVE_WR, CLEAR, RESTORE_RD, APPLY, DONE.
- IDLE:
  - start_save -> SAVE_WR. Capture image = flags_out, sp_next = sp_in - STACK_STEP (mod 2^16), and clear_it.
  - start_restore -> RESTORE_RD. Capture sp_cur = sp_in.
  - Both asserted together: save wins and the restore is dropped.
  - Starts while busy are ignored; they are not queued.
- SAVE_WR:
  - Drives m_access=1, m_wr_en=1, m_addr=sp_next, m_data_out=image.
  - These are held stable until m_ack.
  - On the m_ack cycle, the next cycle has sp_out=sp_next and sp_wr_en=1 for one cycle.
  - Then go to CLEAR if the captured clear_it was set, otherwise DONE.
- CLEAR:
  - One cycle with flags_in=0 and update_flags having only UpdateFlags_IF and UpdateFlags_TF set.
  - Then DONE.
- RESTORE_RD:
  - Drives m_access=1, m_wr_en=0, m_addr=sp_cur.
  - On m_ack, latch m_data_in, then go to APPLY.
- APPLY:
  - One cycle with flags_in=latched data and update_flags=9'h1ff.
  - Same cycle: sp_out = sp_cur + STACK_STEP (mod 2^16), sp_wr_en=1.
  - Then DONE.
- DONE: done=1 for one cycle, then IDLE. busy deasserts in the IDLE cycle after done.
- Outside CLEAR and APPLY, update_flags is 0, so no flag is disturbed.
- Minimum latency with m_ack in the first access cycle, counted from the start cycle:
  - Save without clear: done at cycle +3.
  - Save with clear: done at cycle +4.
  - Restore: done at cycle +3.
- SP wraps: save with SP 0x0000 -> 0xFFFE; restore with SP 0xFFFE -> 0x0000.
- Reserved flag bits in a restored image pass through on flags_in. The Flags register ignores them because no enable bit covers them.

Optional Feature:
- Macro: FLAGS_8086_PUSH_IMAGE_EN.
  - Defined: the pushed image has bits 15:12 forced to 1 and bit 1 forced to 1 (8086 PUSHF image).
  - Undefined: flags_out is pushed unmodified.
- Restore behaviour is identical in both builds.

Test Plan:
- flags_out=16'h0AD7, sp_in=16'h0100, start_save, m_ack one cycle after the request -> write addr 0x00FE, data 0x0AD7 (0xFAD7 with macro), sp_out=0x00FE strobed, done at +3, update_flags stays 0 throughout.
- Save with clear_it=1 and flags_out IF=TF=1 -> exactly one cycle with update_flags = {IF,TF}-only and flags_in=0, then done.
- m_data_in=16'h0C95, sp_in=16'hFFFE, start_restore, m_ack delayed 5 cycles -> m_addr held at 0xFFFE and stable for the whole wait; APPLY cycle has flags_in=0x0C95, update_flags=9'h1ff, sp_out=0x0000.
- Save with sp_in=0x0000 -> m_addr=0xFFFE, sp_out=0xFFFE.
- start_save and start_restore in the same cycle -> only the write occurs; a further start_restore while busy is ignored, so no read is issued afterwards.
- Assert reset while in SAVE_WR awaiting m_ack -> m_access drops with no clock edge needed, and a late m_ack produces no sp_wr_en and no done.

Source files
------------

// File: rtl/flags_stack_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flags_stack_seq : moves the Flags register to/from the stack (PUSHF, INT
// entry, POPF, IRET). Optional macro FLAGS_8086_PUSH_IMAGE_EN.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module flags_stack_seq #(
  parameter int STACK_STEP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_save,
  input  logic        start_restore,
  input  logic        clear_it,
  input  logic [15:0] sp_in,
  input  logic [15:0] flags_out,
  output logic [15:0] flags_in,
  output logic [8:0]  update_flags,
  output logic [15:0] sp_out,
  output logic        sp_wr_en,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_out,
  input  logic [15:0] m_data_in,
  output logic        m_access,
  output logic        m_wr_en,
  input  logic        m_ack,
  output logic        busy,
  output logic        done
);

  localparam int          UPDATE_FLAGS_TF = 5;
  localparam int          UPDATE_FLAGS_IF = 6;
  localparam logic [15:0] STEP            = 16'(STACK_STEP);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_WR    = 3'd1,
    CLEAR      = 3'd2,
    RESTORE_RD = 3'd3,
    APPLY      = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [15:0] image, sp_next, sp_cur, rd_data;
  logic [15:0] push_image;
  logic        clr_pend;
  logic        acked;

`ifdef FLAGS_8086_PUSH_IMAGE_EN
  assign push_image = flags_out | 16'hF002;
`else
  assign push_image = flags_out;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      image    <= '0;
      sp_next  <= '0;
      sp_cur   <= '0;
      rd_data  <= '0;
      clr_pend <= 1'b0;
      acked    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start_save) begin
            image    <= push_image;
            sp_next  <= sp_in - STEP;
            clr_pend <= clear_it;
            acked    <= 1'b0;
          end else if (start_restore) begin
            sp_cur <= sp_in;
          end
        end
        SAVE_WR:    if (!acked && m_ack) acked <= 1'b1;
        RESTORE_RD: if (m_ack) rd_data <= m_data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    flags_in     = '0;
    update_flags = '0;
    sp_out       = '0;
    sp_wr_en     = 1'b0;
    m_addr       = '0;
    m_data_out   = '0;
    m_access     = 1'b0;
    m_wr_en      = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start_save)         state_nx = SAVE_WR;
        else if (start_restore) state_nx = RESTORE_RD;
      end
      SAVE_WR: begin
        // Write phase until acknowledged, then a single SP write-back cycle.
        if (!acked) begin
          m_access   = 1'b1;
          m_wr_en    = 1'b1;
          m_addr     = sp_next;
          m_data_out = image;
        end else begin
          sp_out   = sp_next;
          sp_wr_en = 1'b1;
          state_nx = clr_pend ? CLEAR : DONE;
        end
      end
      CLEAR: begin
        update_flags[UPDATE_FLAGS_IF] = 1'b1;
        update_flags[UPDATE_FLAGS_TF] = 1'b1;
        state_nx = DONE;
      end
      RESTORE_RD: begin
        m_access = 1'b1;
        m_addr   = sp_cur;
        if (m_ack) state_nx = APPLY;
      end
      APPLY: begin
        flags_in     = rd_data;
        update_flags = '1;
        sp_out       = sp_cur + STEP;
        sp_wr_en     = 1'b1;
        state_nx     = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire
